// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver driven by an edge-detected 16x tick, with ready/ack byte handoff
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_sysclk,
    input  logic                 i_reset,
    input  logic                 i_uart_clk,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_rx_data,
    output logic                 o_rx_ready,
    input  logic                 i_rd_ack,
    output logic                 o_overrun,
    output logic                 o_frame_err
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

    state_t                 r_state, w_next;
    logic [SYNC_STAGES-1:0] r_rx_sync, r_uclk_sync;
    logic                   r_uclk_prev;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bit_idx;
    logic [DATA_BITS-1:0]   r_shreg, r_rx_data;
    logic                   r_rx_ready, r_overrun, r_frame_err;
    logic                   w_rx_s, w_tick, w_mid_start, w_mid_bit, w_last_bit;
    logic                   w_deliver, w_ferr_set;

    assign w_rx_s      = r_rx_sync[SYNC_STAGES-1];
    assign w_tick      = r_uclk_sync[SYNC_STAGES-1] & ~r_uclk_prev;
    assign w_mid_start = r_cnt == CW'(OVERSAMPLE/2-1);
    assign w_mid_bit   = r_cnt == CW'(OVERSAMPLE-1);
    assign w_last_bit  = r_bit_idx == BW'(DATA_BITS-1);
    assign o_rx_data   = r_rx_data;
    assign o_rx_ready  = r_rx_ready;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

    // Synchronise rx (idles high) and uart_clk, and keep the previous uart_clk for edge detect
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_rx_sync   <= '1;
            r_uclk_sync <= '0;
            r_uclk_prev <= 1'b0;
        end else begin
            r_rx_sync   <= {r_rx_sync[SYNC_STAGES-2:0], i_rx};
            r_uclk_sync <= {r_uclk_sync[SYNC_STAGES-2:0], i_uart_clk};
            r_uclk_prev <= r_uclk_sync[SYNC_STAGES-1];
        end
    end

    // State register
    always_ff @(posedge i_sysclk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next state: every transition waits for a tick; BREAK needs the line back high before a new start
    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            case (r_state)
                S_IDLE:  if (!w_rx_s) w_next = S_START;
                S_START: if (w_mid_start) w_next = w_rx_s ? S_IDLE : S_DATA;
                S_DATA:  if (w_mid_bit && w_last_bit) w_next = S_STOP;
                S_STOP:  if (w_mid_bit) w_next = w_rx_s ? S_IDLE : S_BREAK;
                S_BREAK: if (w_rx_s) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Outputs of the FSM: stop-bit sample either delivers the byte or flags a framing error
    always_comb begin
        w_deliver  = w_tick && r_state == S_STOP && w_mid_bit && w_rx_s;
        w_ferr_set = w_tick && r_state == S_STOP && w_mid_bit && !w_rx_s;
    end

    // Tick counter, bit index and LSB-first shift register, all advancing only on tick
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
        end else if (w_tick) begin
            case (r_state)
                S_START:        r_cnt <= w_mid_start ? '0 : r_cnt + 1'b1;
                S_DATA, S_STOP: r_cnt <= w_mid_bit ? '0 : r_cnt + 1'b1;
                default:        r_cnt <= '0;
            endcase
            if (r_state == S_START && w_mid_start) r_bit_idx <= '0;
            if (r_state == S_DATA && w_mid_bit) begin
                r_shreg   <= {w_rx_s, r_shreg[DATA_BITS-1:1]};
                r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
            end
        end
    end

    // Handshake: deliver beats a simultaneous ack, ack clears the sticky flags every sysclk
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            r_rx_data   <= '0;
            r_rx_ready  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_deliver) r_rx_data <= r_shreg;
            r_rx_ready  <= w_deliver | (r_rx_ready & ~i_rd_ack);
            r_overrun   <= ~i_rd_ack & (r_overrun | (w_deliver & r_rx_ready));
            r_frame_err <= w_ferr_set | (r_frame_err & ~i_rd_ack & ~w_deliver);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against uart_rx with hand-computed expected bytes and flags
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int TICK = 8;
    localparam int BT   = 16 * TICK;

    logic       clk = 1'b0, rst = 1'b1, uclk = 1'b0, rx = 1'b1, ack = 1'b0;
    logic [7:0] data;
    logic       ready, ovr, ferr;
    logic [7:0] partial;
    int         n_tests = 0, n_fail = 0;

    uart_rx dut (
        .i_sysclk(clk), .i_reset(rst), .i_uart_clk(uclk), .i_rx(rx),
        .o_rx_data(data), .o_rx_ready(ready), .i_rd_ack(ack),
        .o_overrun(ovr), .o_frame_err(ferr)
    );

    always #10 clk = ~clk;

    // One-sysclk uart_clk pulse every TICK cycles
    initial forever begin
        repeat (TICK-1) @(negedge clk);
        uclk = 1'b1;
        @(negedge clk);
        uclk = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        line(1'b0, BT);
        for (int i = 0; i < 8; i++) line(b[i], BT);
        line(stop, BT);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        line(1'b1, 2*BT);
        check("rst_ready", ready, 0);
        check("rst_ovr", ovr, 0);
        check("rst_ferr", ferr, 0);
        check("rst_data", data, 8'h00);

        send(8'h55, 1'b1);
        check("b55_ready", ready, 1);
        check("b55_data", data, 8'h55);
        pulse_ack();
        check("b55_ack_ready", ready, 0);

        line(1'b0, 3*TICK);
        line(1'b1, 2*BT);
        check("glitch_ready", ready, 0);
        send(8'hA3, 1'b1);
        check("bA3_ready", ready, 1);
        check("bA3_data", data, 8'hA3);
        pulse_ack();

        send(8'h12, 1'b1);
        send(8'h34, 1'b1);
        check("ovr_data", data, 8'h34);
        check("ovr_ready", ready, 1);
        check("ovr_flag", ovr, 1);
        pulse_ack();
        check("ovr_ack_flag", ovr, 0);
        check("ovr_ack_ready", ready, 0);

        send(8'hFF, 1'b0);
        line(1'b0, 3*BT);
        line(1'b1, 2*BT);
        check("ferr_flag", ferr, 1);
        check("ferr_ready", ready, 0);
        check("ferr_data", data, 8'h34);
        send(8'h0F, 1'b1);
        check("b0F_data", data, 8'h0F);
        check("b0F_ferr", ferr, 0);
        check("b0F_ready", ready, 1);

        partial = 8'hC3;
        line(1'b0, BT);
        for (int i = 0; i < 5; i++) line(partial[i], BT);
        line(partial[5], 12*TICK);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_data", data, 8'h00);
        check("midrst_ready", ready, 0);
        check("midrst_ovr", ovr, 0);
        check("midrst_ferr", ferr, 0);
        line(partial[5], 4*TICK - 1);
        line(1'b1, 4*BT);
        check("midrst_tail_ready", ready, 0);
        send(8'h3C, 1'b1);
        check("b3C_data", data, 8'h3C);
        check("b3C_ready", ready, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
